// File: rtl/chip8_mem_if.sv
// Processor <-> memory-responder request/response bus.
// master: chip8 processor side, slave: chip8_mem_responder side.
interface chip8_mem_if;
    logic [11:0] proc_addr_in;
    logic        proc_we_in;
    logic        proc_valid_in;
    logic [7:0]  proc_data_in;
    logic [1:0]  proc_type_in;
    logic        proc_ready_out;
    logic        proc_valid_out;
    logic [7:0]  proc_data_out;

    modport master (
        output proc_addr_in,
        output proc_we_in,
        output proc_valid_in,
        output proc_data_in,
        output proc_type_in,
        input  proc_ready_out,
        input  proc_valid_out,
        input  proc_data_out
    );

    modport slave (
        input  proc_addr_in,
        input  proc_we_in,
        input  proc_valid_in,
        input  proc_data_in,
        input  proc_type_in,
        output proc_ready_out,
        output proc_valid_out,
        output proc_data_out
    );
endinterface

// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder: serves processor memory requests. REG-type requests hit
// the internal architectural register file (V0-VF, I, PC, DT, ST, SP); RAM-type
// requests pass straight through to the external BRAM port. Every accepted read
// returns exactly READ_LATENCY cycles later, in issue order.
// Optional feature macro: CHIP8_MEM_TIMERS_EN (60 Hz DT/ST decrement + audio).
module chip8_mem_responder #(
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [11:0] PC_RESET     = 12'h200
) (
    input  logic        clk_in,
    input  logic        rst_in,
    chip8_mem_if.slave  bus,
    input  logic        ram_busy_in,
    output logic [11:0] ram_addr_out,
    output logic        ram_en_out,
    output logic        ram_we_out,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in,
    input  logic        timer_decr_in,
    output logic        audio_out,
    output logic [1:0]  error_out
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 23;
    localparam int unsigned REG_PCH  = 18;
    localparam int unsigned REG_PCL  = 19;
`ifdef CHIP8_MEM_TIMERS_EN
    localparam int unsigned REG_DT   = 20;
    localparam int unsigned REG_ST   = 21;
`endif

    localparam logic [1:0] TYPE_RAM = 2'd0;
    localparam logic [1:0] TYPE_REG = 2'd1;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_TYPE = 2'd1;
    localparam logic [1:0] ERR_BAD_REG  = 2'd2;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              ready;
    logic              accept;
    logic              is_ram;
    logic              is_reg;
    logic              bad_type;
    logic [4:0]        reg_idx;
    logic              reg_addr_ok;
    logic              rd_accept;
    logic              reg_wr;
    logic [DATA_W-1:0] rd_data;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_ram;
    logic [DATA_W-1:0]       pipe_data [READ_LATENCY];

    // Request decode; readiness gates every type so ordering stays trivial.
    always_comb begin
        ready       = !ram_busy_in && !rst_in;
        accept      = bus.proc_valid_in && ready;
        is_ram      = (bus.proc_type_in == TYPE_RAM);
        is_reg      = (bus.proc_type_in == TYPE_REG);
        bad_type    = bus.proc_type_in[1];
        reg_idx     = bus.proc_addr_in[4:0];
        reg_addr_ok = (bus.proc_addr_in[11:5] == 7'd0) && (reg_idx < 5'(NUM_REGS));
        rd_accept   = accept && !bus.proc_we_in;
        reg_wr      = accept && bus.proc_we_in && is_reg && reg_addr_ok;
        rd_data     = '0;
        if (is_reg && reg_addr_ok) begin
            rd_data = regs[reg_idx];
        end
    end

    assign bus.proc_ready_out = ready;

    // BRAM port is a same-cycle passthrough of accepted RAM requests.
    always_comb begin
        ram_en_out   = accept && is_ram;
        ram_we_out   = accept && is_ram && bus.proc_we_in;
        ram_addr_out = bus.proc_addr_in;
        ram_data_out = bus.proc_data_in;
    end

    // Architectural register file; a processor write beats a timer decrement.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            regs[REG_PCH] <= {4'h0, PC_RESET[11:8]};
            regs[REG_PCL] <= PC_RESET[7:0];
        end else begin
`ifdef CHIP8_MEM_TIMERS_EN
            if (timer_decr_in) begin
                if (regs[REG_DT] != 8'd0) begin
                    regs[REG_DT] <= regs[REG_DT] - 8'd1;
                end
                if (regs[REG_ST] != 8'd0) begin
                    regs[REG_ST] <= regs[REG_ST] - 8'd1;
                end
            end
`endif
            if (reg_wr) begin
                regs[reg_idx] <= bus.proc_data_in;
            end
        end
    end

`ifdef CHIP8_MEM_TIMERS_EN
    // Sound is on while the sound timer is nonzero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= (regs[REG_ST] != 8'd0);
        end
    end
`else
    logic unused_timer_decr;
    assign unused_timer_decr = timer_decr_in;
    assign audio_out         = 1'b0;
`endif

    // Sticky error: first offending request wins until reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            error_out <= ERR_NONE;
        end else if (accept && (error_out == ERR_NONE)) begin
            if (bad_type) begin
                error_out <= ERR_BAD_TYPE;
            end else if (is_reg && !reg_addr_ok) begin
                error_out <= ERR_BAD_REG;
            end
        end
    end

    // Read-response delay line; REG data rides along, RAM data joins at the end.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_valid <= '0;
            pipe_ram   <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_ram[i]   <= pipe_ram[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            pipe_valid[0] <= rd_accept;
            pipe_ram[0]   <= rd_accept && is_ram;
            pipe_data[0]  <= rd_data;
        end
    end

    // Response output; RAM data is taken from the BRAM in the response cycle.
    always_comb begin
        bus.proc_valid_out = pipe_valid[READ_LATENCY-1] && !rst_in;
        bus.proc_data_out  = '0;
        if (bus.proc_valid_out) begin
            bus.proc_data_out = pipe_ram[READ_LATENCY-1] ? ram_data_in
                                                         : pipe_data[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed bench for chip8_mem_responder with a 2-cycle BRAM model.
module tb_chip8_mem_responder;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        ram_busy_in;
    logic        timer_decr_in;
    logic [11:0] ram_addr_out;
    logic        ram_en_out;
    logic        ram_we_out;
    logic [7:0]  ram_data_out;
    logic [7:0]  ram_data_in;
    logic        audio_out;
    logic [1:0]  error_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chip8_mem_if bus ();

    chip8_mem_responder #(
        .READ_LATENCY (2),
        .PC_RESET     (12'h200)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .bus           (bus.slave),
        .ram_busy_in   (ram_busy_in),
        .ram_addr_out  (ram_addr_out),
        .ram_en_out    (ram_en_out),
        .ram_we_out    (ram_we_out),
        .ram_data_out  (ram_data_out),
        .ram_data_in   (ram_data_in),
        .timer_decr_in (timer_decr_in),
        .audio_out     (audio_out),
        .error_out     (error_out)
    );

    // 4 KiB BRAM with 2-cycle read latency.
    logic [7:0] mem [4096];
    logic [7:0] mem_q1;
    always @(posedge clk) begin
        if (ram_en_out) begin
            if (ram_we_out) mem[ram_addr_out] <= ram_data_out;
            mem_q1 <= mem[ram_addr_out];
        end
        ram_data_in <= mem_q1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, settle before sampling.
    task automatic cyc(input logic r, input logic busy, input logic decr,
                       input logic v, input logic we, input logic [1:0] ty,
                       input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_in             = r;
        ram_busy_in        = busy;
        timer_decr_in      = decr;
        bus.proc_valid_in  = v;
        bus.proc_we_in     = we;
        bus.proc_type_in   = ty;
        bus.proc_addr_in   = a;
        bus.proc_data_in   = d;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 8'h00);
    endtask

    task automatic rd(input logic [1:0] ty, input logic [11:0] a);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ty, a, 8'h00);
    endtask

    task automatic wr(input logic [1:0] ty, input logic [11:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ty, a, d);
    endtask

    task automatic resp(input string tag, input logic v, input logic [7:0] d);
        check({tag, "_valid"}, 32'(bus.proc_valid_out), 32'(v));
        if (v) check({tag, "_data"}, 32'(bus.proc_data_out), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h6A;
        mem[12'h201] = 8'h5C;
        mem_q1       = 8'h00;
        ram_data_in  = 8'h00;
        rst_in = 1'b1; ram_busy_in = 1'b0; timer_decr_in = 1'b0;
        bus.proc_valid_in = 1'b0; bus.proc_we_in = 1'b0; bus.proc_type_in = 2'd0;
        bus.proc_addr_in = 12'h000; bus.proc_data_in = 8'h00;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 12'h012, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 12'h012, 8'h00);
        check("rst_ready", 32'(bus.proc_ready_out), 32'd0);
        check("rst_ram_en", 32'(ram_en_out), 32'd0);
        idle();
        check("post_rst_valid", 32'(bus.proc_valid_out), 32'd0);
        check("post_rst_data", 32'(bus.proc_data_out), 32'h00);
        check("post_rst_err", 32'(error_out), 32'd0);
        check("post_rst_audio", 32'(audio_out), 32'd0);
        check("post_rst_ready", 32'(bus.proc_ready_out), 32'd1);

        // PC reset value through back-to-back REG reads
        rd(2'd1, 12'h012);
        resp("pc_c0", 1'b0, 8'h00);
        rd(2'd1, 12'h013);
        resp("pc_c1", 1'b0, 8'h00);
        idle(); resp("pc_hi", 1'b1, 8'h02);
        idle(); resp("pc_lo", 1'b1, 8'h00);
        idle(); resp("pc_done", 1'b0, 8'h00);

        // REG write then immediate read
        wr(2'd1, 12'h005, 8'hA7);
        resp("wr5_c0", 1'b0, 8'h00);
        rd(2'd1, 12'h005);
        idle(); resp("wr5_noresp", 1'b0, 8'h00);
        idle(); resp("rd5", 1'b1, 8'hA7);

        // RAM read then REG read, in order
        wr(2'd1, 12'h003, 8'h11);
        idle();
        rd(2'd0, 12'h200);
        check("ram_rd_en", 32'(ram_en_out), 32'd1);
        check("ram_rd_we", 32'(ram_we_out), 32'd0);
        check("ram_rd_addr", 32'(ram_addr_out), 32'h200);
        rd(2'd1, 12'h003);
        check("reg_rd_no_ram_en", 32'(ram_en_out), 32'd0);
        idle(); resp("mix_ram", 1'b1, 8'h6A);
        idle(); resp("mix_reg", 1'b1, 8'h11);
        idle(); resp("mix_done", 1'b0, 8'h00);

        // RAM write passthrough, then read back
        wr(2'd0, 12'h300, 8'h99);
        check("ram_wr_en", 32'(ram_en_out), 32'd1);
        check("ram_wr_we", 32'(ram_we_out), 32'd1);
        check("ram_wr_addr", 32'(ram_addr_out), 32'h300);
        check("ram_wr_data", 32'(ram_data_out), 32'h99);
        rd(2'd0, 12'h300);
        idle(); resp("ram_wr_noresp", 1'b0, 8'h00);
        idle(); resp("ram_wb", 1'b1, 8'h99);

        // Busy stalls everything
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'h201, 8'h00);
            check("busy_ready", 32'(bus.proc_ready_out), 32'd0);
            check("busy_ram_en", 32'(ram_en_out), 32'd0);
            resp("busy_noresp", 1'b0, 8'h00);
        end
        rd(2'd0, 12'h201);
        check("unbusy_ready", 32'(bus.proc_ready_out), 32'd1);
        check("unbusy_ram_en", 32'(ram_en_out), 32'd1);
        idle(); resp("unbusy_c1", 1'b0, 8'h00);
        idle(); resp("unbusy_resp", 1'b1, 8'h5C);
        idle(); resp("unbusy_done", 1'b0, 8'h00);

        // Invalid type, then bad REG address: first error sticks
        check("err_before", 32'(error_out), 32'd0);
        rd(2'd3, 12'h005);
        rd(2'd1, 12'h020);
        check("err_type", 32'(error_out), 32'd1);
        idle(); resp("bad_type_rd", 1'b1, 8'h00);
        check("err_sticky0", 32'(error_out), 32'd1);
        idle(); resp("bad_reg_rd", 1'b1, 8'h00);
        check("err_sticky1", 32'(error_out), 32'd1);
        wr(2'd2, 12'h005, 8'h55);
        rd(2'd1, 12'h005);
        idle(); idle(); resp("bad_type_wr_ignored", 1'b1, 8'hA7);

`ifdef CHIP8_MEM_TIMERS_EN
        // Sound timer countdown and audio
        wr(2'd1, 12'h015, 8'h02);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 12'h015, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 12'h015, 8'h00);
        check("audio_on", 32'(audio_out), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 12'h015, 8'h00);
        resp("st_2", 1'b1, 8'h02);
        check("audio_still_on", 32'(audio_out), 32'd1);
        rd(2'd1, 12'h015);
        resp("st_1", 1'b1, 8'h01);
        check("audio_off", 32'(audio_out), 32'd0);
        idle(); resp("st_0a", 1'b1, 8'h00);
        idle(); resp("st_0b", 1'b1, 8'h00);
`else
        // Timers are plain storage
        wr(2'd1, 12'h014, 8'h05);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 8'h00);
        rd(2'd1, 12'h014);
        idle(); idle(); resp("dt_plain", 1'b1, 8'h05);
        check("audio_tied", 32'(audio_out), 32'd0);
`endif

        // Reset with a read in flight drops the response
        rd(2'd1, 12'h005);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 8'h00);
        resp("rst_flight_c1", 1'b0, 8'h00);
        idle(); resp("rst_flight_c2", 1'b0, 8'h00);
        check("rst_err_clear", 32'(error_out), 32'd0);
        idle(); resp("rst_flight_c3", 1'b0, 8'h00);
        rd(2'd1, 12'h005);
        idle(); idle(); resp("rst_reg_clear", 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
